// File: rtl/mem_pkg.sv
`default_nettype none
// Shared memory-subsystem definitions: line geometry, cache constants,
// store-buffer drain states and the byte-lane mask helper.
package mem_pkg;

  localparam int LINE_OFFSET_BITS = 4;
  localparam int LINE_BYTES       = 16;
  localparam int CACHE_LINE_BITS  = 128;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_READ  = 2'd1,
    SB_WRITE = 2'd2
  } sb_state_e;

  // Lanes touched by a store: one byte for STB, an aligned word for STW.
  function automatic logic [LINE_BYTES-1:0] sb_byte_mask(
    input logic                        is_byte,
    input logic [LINE_OFFSET_BITS-1:0] offset
  );
    logic [LINE_BYTES-1:0] mask;
    if (is_byte) mask = 16'h0001 << offset;
    else         mask = 16'h000F << {offset[3:2], 2'b00};
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_entry_array.sv
`default_nettype none
// Store-buffer line storage: tag/data/mask per entry, with a masked store
// port (allocate or merge) and a fill port that only touches unwritten bytes.
module sb_entry_array
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_BITS  = 28,
  parameter int LINE_BITS = 128
) (
  input  logic                       clk,
  input  logic                       st_we_i,
  input  logic                       st_alloc_i,
  input  logic [$clog2(DEPTH)-1:0]   st_idx_i,
  input  logic [TAG_BITS-1:0]        st_tag_i,
  input  logic [LINE_BITS/8-1:0]     st_mask_i,
  input  logic [LINE_BITS-1:0]       st_data_i,
  input  logic                       fill_en_i,
  input  logic [$clog2(DEPTH)-1:0]   fill_idx_i,
  input  logic [LINE_BITS-1:0]       fill_data_i,
  input  logic [$clog2(DEPTH)-1:0]   head_idx_i,
  output logic [TAG_BITS-1:0]        head_tag_o,
  output logic [LINE_BITS-1:0]       head_data_o,
  output logic [LINE_BITS/8-1:0]     head_mask_o,
  input  logic [$clog2(DEPTH)-1:0]   tail_idx_i,
  output logic [TAG_BITS-1:0]        tail_tag_o
);

  localparam int NB = LINE_BITS / 8;

  logic [TAG_BITS-1:0]  tag_q  [DEPTH];
  logic [LINE_BITS-1:0] data_q [DEPTH];
  logic [NB-1:0]        mask_q [DEPTH];

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (!mask_q[fill_idx_i][b]) data_q[fill_idx_i][8*b +: 8] <= fill_data_i[8*b +: 8];
      end
    end
    if (st_we_i) begin
      if (st_alloc_i) begin
        tag_q[st_idx_i]  <= st_tag_i;
        mask_q[st_idx_i] <= st_mask_i;
      end else begin
        mask_q[st_idx_i] <= mask_q[st_idx_i] | st_mask_i;
      end
      for (int b = 0; b < NB; b++) begin
        if (st_mask_i[b]) data_q[st_idx_i][8*b +: 8] <= st_data_i[8*b +: 8];
      end
    end
  end

  assign head_tag_o  = tag_q[head_idx_i];
  assign head_data_o = data_q[head_idx_i];
  assign head_mask_o = mask_q[head_idx_i];
  assign tail_tag_o  = tag_q[tail_idx_i];

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// Coalescing line store buffer: merges stores into the youngest line and
// drains lines in order, reading memory first when a line is only partly written.
module store_buffer
  import mem_pkg::*;
#(
  parameter int ARCH_BITS        = 32,
  parameter int MEMORY_LINE_BITS = CACHE_LINE_BITS,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        st_valid,
  input  logic                        st_byte,
  input  logic [ARCH_BITS-1:0]        st_addr,
  input  logic [ARCH_BITS-1:0]        st_data,
  output logic                        st_ready,
  output logic [ARCH_BITS-1:0]        mem_read_addr,
  output logic                        mem_read_req,
  input  logic [MEMORY_LINE_BITS-1:0] mem_data,
  input  logic                        mem_data_valid,
  output logic [ARCH_BITS-1:0]        mem_write_addr,
  output logic [MEMORY_LINE_BITS-1:0] mem_write_data,
  output logic                        mem_write_req,
  input  logic                        mem_write_done,
  output logic                        empty
);

  localparam int TAG_BITS = ARCH_BITS - LINE_OFFSET_BITS;
  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = IDX_BITS + 1;
  localparam int NB       = MEMORY_LINE_BITS / 8;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  sb_state_e            state_q, state_d;
  logic [IDX_BITS-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic                 lock_q, lock_d;

  logic [TAG_BITS-1:0]         st_tag, head_tag, tail_tag;
  logic [NB-1:0]               st_mask, head_mask;
  logic [MEMORY_LINE_BITS-1:0] st_line, head_data;
  logic [IDX_BITS-1:0]         tail_last;
  logic                        coalesce_hit, accept, push, pop, fill_en;

  assign st_tag    = st_addr[ARCH_BITS-1:LINE_OFFSET_BITS];
  assign st_mask   = sb_byte_mask(st_byte, st_addr[LINE_OFFSET_BITS-1:0]);
  assign st_line   = st_byte ? {NB{st_data[7:0]}} : {(MEMORY_LINE_BITS/ARCH_BITS){st_data}};
  assign tail_last = tail_q - 1'b1;

  // The youngest entry only refuses merges while it is the head being drained.
  assign coalesce_hit = (count_q != '0) && valid_q[tail_last] && (tail_tag == st_tag) &&
                        !(lock_q && (tail_last == head_q));
  assign st_ready = (count_q < FULL_CNT) || coalesce_hit;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !coalesce_hit;
  assign empty    = (count_q == '0) && (state_q == SB_IDLE);

  sb_entry_array #(
    .DEPTH     (DEPTH),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (MEMORY_LINE_BITS)
  ) u_entries (
    .clk         (clk),
    .st_we_i     (accept),
    .st_alloc_i  (push),
    .st_idx_i    (push ? tail_q : tail_last),
    .st_tag_i    (st_tag),
    .st_mask_i   (st_mask),
    .st_data_i   (st_line),
    .fill_en_i   (fill_en),
    .fill_idx_i  (head_q),
    .fill_data_i (mem_data),
    .head_idx_i  (head_q),
    .head_tag_o  (head_tag),
    .head_data_o (head_data),
    .head_mask_o (head_mask),
    .tail_idx_i  (tail_last),
    .tail_tag_o  (tail_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    lock_d         = lock_q;
    pop            = 1'b0;
    fill_en        = 1'b0;
    mem_read_req   = 1'b0;
    mem_read_addr  = '0;
    mem_write_req  = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;

    case (state_q)
      SB_IDLE: begin
        if (count_q != '0) begin
          lock_d  = 1'b1;
          state_d = (&head_mask) ? SB_WRITE : SB_READ;
        end
      end
      SB_READ: begin
        mem_read_req  = 1'b1;
        mem_read_addr = {head_tag, {LINE_OFFSET_BITS{1'b0}}};
        if (mem_data_valid) begin
          fill_en = 1'b1;
          state_d = SB_WRITE;
        end
      end
      SB_WRITE: begin
        mem_write_req  = 1'b1;
        mem_write_addr = {head_tag, {LINE_OFFSET_BITS{1'b0}}};
        mem_write_data = head_data;
        if (mem_write_done) begin
          pop     = 1'b1;
          lock_d  = 1'b0;
          state_d = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase

    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    valid_d = valid_q;
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// Directed self-checking bench for store_buffer with a small line-memory responder.
module tb_store_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_valid = 1'b0, st_byte = 1'b0;
  logic [31:0]  st_addr = '0, st_data = '0;
  logic         st_ready;
  logic [31:0]  mem_read_addr, mem_write_addr;
  logic         mem_read_req, mem_write_req, empty;
  logic [127:0] mem_data = '0, mem_write_data;
  logic         mem_data_valid = 1'b0, mem_write_done = 1'b0;

  always #5 clk = ~clk;

  store_buffer #(.ARCH_BITS(32), .MEMORY_LINE_BITS(128), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_byte(st_byte), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .mem_read_addr(mem_read_addr), .mem_read_req(mem_read_req),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_req(mem_write_req), .mem_write_done(mem_write_done),
    .empty(empty)
  );

  int n_cmp = 0, n_mis = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: answers a request on its second cycle unless held off.
  logic         auto_read = 1'b1, hold_write = 1'b0;
  logic [127:0] mem_line = '0;
  int           rd_wait = 0, wr_wait = 0, both_high = 0, unstable = 0, req_seen = 0;
  logic         prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0]  prev_rd_addr = '0, prev_wr_addr = '0;
  logic [127:0] prev_wr_data = '0;
  logic [31:0]  rd_log[$], wr_addr_log[$];
  logic [127:0] wr_data_log[$];

  always @(negedge clk) begin
    mem_data_valid = 1'b0;
    mem_write_done = 1'b0;
    if (rst) begin
      rd_wait = 0; wr_wait = 0; prev_rd = 1'b0; prev_wr = 1'b0;
    end else begin
      if (mem_read_req && mem_write_req) both_high++;
      if (mem_read_req || mem_write_req) req_seen++;
      if (prev_rd && mem_read_req && (mem_read_addr !== prev_rd_addr)) unstable++;
      if (prev_wr && mem_write_req &&
          ((mem_write_addr !== prev_wr_addr) || (mem_write_data !== prev_wr_data))) unstable++;
      prev_rd = mem_read_req;  prev_rd_addr = mem_read_addr;
      prev_wr = mem_write_req; prev_wr_addr = mem_write_addr; prev_wr_data = mem_write_data;
      if (mem_read_req && auto_read) begin
        rd_wait++;
        if (rd_wait == 2) begin
          mem_data = mem_line; mem_data_valid = 1'b1;
          rd_log.push_back(mem_read_addr);
          rd_wait = 0; prev_rd = 1'b0;
        end
      end
      if (mem_write_req && !hold_write) begin
        wr_wait++;
        if (wr_wait == 2) begin
          mem_write_done = 1'b1;
          wr_addr_log.push_back(mem_write_addr);
          wr_data_log.push_back(mem_write_data);
          wr_wait = 0; prev_wr = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
  endtask

  // Present a store at a falling edge and hold it until accepted.
  task automatic store(input logic b, input logic [31:0] a, input logic [31:0] d);
    int g;
    g = 0;
    st_valid = 1'b1; st_byte = b; st_addr = a; st_data = d;
    #1;
    while (!st_ready && g < 100) begin
      @(negedge clk); #1; g++;
    end
    if (g >= 100) check_eq("store_accept_timeout", 128'(st_ready), 128'd1);
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int g;
    g = 0;
    while (!empty && g < 300) begin
      @(negedge clk); g++;
    end
    check_eq(tag, 128'(empty), 128'd1);
  endtask

  initial begin
    int g;
    tick(3);
    rst = 1'b0;
    #1;
    check_eq("rst_empty",      128'(empty),          128'd1);
    check_eq("rst_st_ready",   128'(st_ready),       128'd1);
    check_eq("rst_rd_req",     128'(mem_read_req),   128'd0);
    check_eq("rst_wr_req",     128'(mem_write_req),  128'd0);
    check_eq("rst_rd_addr",    128'(mem_read_addr),  128'd0);
    check_eq("rst_wr_addr",    128'(mem_write_addr), 128'd0);
    check_eq("rst_wr_data",    mem_write_data,       128'd0);
    @(negedge clk);

    // Full line assembled behind a blocked head drains with no read.
    clear_logs(); auto_read = 1'b0; mem_line = {128{1'b1}};
    store(1'b0, 32'h500, 32'h0000DEAD);
    tick(2);
    check_eq("full_blocker_read", 128'(mem_read_req), 128'd1);
    store(1'b0, 32'h100, 32'h11111111);
    store(1'b0, 32'h104, 32'h22222222);
    store(1'b0, 32'h108, 32'h33333333);
    store(1'b0, 32'h10C, 32'h44444444);
    auto_read = 1'b1;
    wait_empty("full_drain");
    check_eq("full_n_reads",  128'(rd_log.size()),      128'd1);
    check_eq("full_rd_addr0", 128'(rd_log[0]),          128'h500);
    check_eq("full_n_writes", 128'(wr_addr_log.size()), 128'd2);
    check_eq("full_blk_data", wr_data_log[0], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_0000DEAD);
    check_eq("full_wr_addr",  128'(wr_addr_log[1]),     128'h100);
    check_eq("full_wr_data",  wr_data_log[1], 128'h44444444_33333333_22222222_11111111);

    // Partial line merge with read fill.
    clear_logs(); mem_line = {128{1'b1}};
    store(1'b1, 32'h203, 32'h123456AB);
    wait_empty("part_drain");
    check_eq("part_n_reads",  128'(rd_log.size()),      128'd1);
    check_eq("part_rd_addr",  128'(rd_log[0]),          128'h200);
    check_eq("part_wr_addr",  128'(wr_addr_log[0]),     128'h200);
    check_eq("part_wr_data",  wr_data_log[0], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_ABFFFFFF);

    // Back-pressure with a full buffer; tail coalescing still accepted.
    clear_logs(); hold_write = 1'b1; mem_line = '0;
    store(1'b0, 32'h000, 32'hA0);
    store(1'b0, 32'h010, 32'hA1);
    store(1'b0, 32'h020, 32'hA2);
    store(1'b0, 32'h030, 32'hA3);
    st_valid = 1'b1; st_byte = 1'b0; st_addr = 32'h040; st_data = 32'hA4;
    #1;
    check_eq("bp_full_ready", 128'(st_ready), 128'd0);
    st_addr = 32'h030; st_data = 32'hC3;
    #1;
    check_eq("bp_coalesce_ready", 128'(st_ready), 128'd1);
    @(negedge clk);
    st_addr = 32'h040; st_data = 32'hA4;
    #1;
    check_eq("bp_still_full", 128'(st_ready), 128'd0);
    hold_write = 1'b0;
    store(1'b0, 32'h040, 32'hA4);
    wait_empty("bp_drain");
    check_eq("bp_n_writes", 128'(wr_addr_log.size()), 128'd5);
    check_eq("bp_wr_addr0", 128'(wr_addr_log[0]),     128'h000);
    check_eq("bp_wr_addr3", 128'(wr_addr_log[3]),     128'h030);
    check_eq("bp_wr_data3", wr_data_log[3],           128'h000000C3);
    check_eq("bp_wr_addr4", 128'(wr_addr_log[4]),     128'h040);
    check_eq("bp_wr_data4", wr_data_log[4],           128'h000000A4);

    // Store to the locked head line allocates a second entry.
    clear_logs(); auto_read = 1'b0; mem_line = '0;
    store(1'b0, 32'h300, 32'h1111);
    tick(2);
    check_eq("lock_rd_addr", 128'(mem_read_addr), 128'h300);
    store(1'b0, 32'h304, 32'h55);
    auto_read = 1'b1;
    wait_empty("lock_drain");
    check_eq("lock_n_reads",  128'(rd_log.size()),      128'd2);
    check_eq("lock_n_writes", 128'(wr_addr_log.size()), 128'd2);
    check_eq("lock_wr_addr0", 128'(wr_addr_log[0]),     128'h300);
    check_eq("lock_wr_data0", wr_data_log[0],           128'h00001111);
    check_eq("lock_wr_addr1", 128'(wr_addr_log[1]),     128'h300);
    check_eq("lock_wr_word1", 128'(wr_data_log[1][63:32]), 128'h55);

    // Reset while a write is outstanding abandons everything.
    clear_logs(); hold_write = 1'b1; mem_line = '0;
    store(1'b0, 32'h600, 32'h66);
    store(1'b0, 32'h610, 32'h61);
    g = 0;
    while (!mem_write_req && g < 50) begin
      @(negedge clk); g++;
    end
    check_eq("rstw_req_seen", 128'(mem_write_req), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstw_wr_req", 128'(mem_write_req), 128'd0);
    check_eq("rstw_rd_req", 128'(mem_read_req),  128'd0);
    check_eq("rstw_empty",  128'(empty),         128'd1);
    req_seen = 0; hold_write = 1'b0;
    tick(10);
    check_eq("rstw_no_reqs",   128'(req_seen),           128'd0);
    check_eq("rstw_no_writes", 128'(wr_addr_log.size()), 128'd0);

    // Drain order follows allocation order.
    clear_logs(); mem_line = '0;
    store(1'b0, 32'h400, 32'h1);
    store(1'b0, 32'h410, 32'h2);
    wait_empty("ord_drain");
    check_eq("ord_n_writes", 128'(wr_addr_log.size()), 128'd2);
    check_eq("ord_wr_addr0", 128'(wr_addr_log[0]),     128'h400);
    check_eq("ord_wr_data0", wr_data_log[0],           128'h1);
    check_eq("ord_wr_addr1", 128'(wr_addr_log[1]),     128'h410);
    check_eq("ord_wr_data1", wr_data_log[1],           128'h2);

    check_eq("req_exclusive", 128'(both_high), 128'd0);
    check_eq("req_stable",    128'(unstable),  128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
